car_sensor_driver: RTL

- Stimulus generator for the parking-lot gate: the transmitter side of the two-sensor (outer/inner) car protocol.
- On a single-cycle request it drives a legal car-entering or car-exiting sensor waveform with programmable dwell per phase.
- Supports a back-out (abort) that reverses the car so no completion must be counted.
- Used in lab benches and on-board demos to feed the car detector and the occupancy counter without physical switches.

---
 rtl/car_sensor_driver.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/car_sensor_driver.sv
// Car sensor driver: plays a legal two-sensor (outer/inner) car waveform
// for the parking-lot gate, entering or exiting, with a programmable dwell
// per phase, optional back-out, and counters of completed sequences.
module car_sensor_driver #(
    parameter int DWELL_W = 8,
    parameter int GAP     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_enter,
    input  logic               req_exit,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               abort,
    output logic               ready,
    output logic               outer,
    output logic               inner,
    output logic               done,
    output logic [7:0]         enter_cnt,
    output logic [7:0]         exit_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        P1,
        P2,
        P3,
        B2,
        B1,
        POST
    } state_t;

    // POST counts down from GAP-1 to 0, so it only needs to hold GAP-1
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

    state_t             state;
    logic               dir;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt;
    logic [GW-1:0]      gap_cnt;

    // Sensor pair {outer, inner} for a state; the first sensor is outer when
    // entering (d=0) and inner when exiting (d=1)
    function automatic logic [1:0] sens(input state_t s, input logic d);
        logic f;
        logic sn;
        f  = 1'b0;
        sn = 1'b0;
        case (s)
            P1, B1:  f = 1'b1;
            P2, B2:  begin f = 1'b1; sn = 1'b1; end
            P3:      sn = 1'b1;
            default: begin f = 1'b0; sn = 1'b0; end
        endcase
        return d ? {sn, f} : {f, sn};
    endfunction

    // Sequence FSM: every output is loaded together with the next state, so
    // outputs are pure functions of registered state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dir       <= 1'b0;
            dwell_q   <= DWELL_W'(1);
            cnt       <= '0;
            gap_cnt   <= '0;
            ready     <= 1'b1;
            outer     <= 1'b0;
            inner     <= 1'b0;
            done      <= 1'b0;
            enter_cnt <= 8'd0;
            exit_cnt  <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_enter ^ req_exit) begin
                        state          <= P1;
                        dir            <= req_exit;
                        dwell_q        <= (dwell == '0) ? DWELL_W'(1) : dwell;
                        cnt            <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                        ready          <= 1'b0;
                        {outer, inner} <= sens(P1, req_exit);
                    end
                end
                P1: begin
                    if (abort) begin
                        state          <= POST;
                        gap_cnt        <= GAP_LOAD;
                        {outer, inner} <= 2'b00;
                    end else if (cnt == '0) begin
                        state          <= P2;
                        cnt            <= dwell_q - DWELL_W'(1);
                        {outer, inner} <= sens(P2, dir);
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                P2: begin
                    if (abort) begin
                        state          <= B1;
                        cnt            <= dwell_q - DWELL_W'(1);
                        {outer, inner} <= sens(B1, dir);
                    end else if (cnt == '0) begin
                        state          <= P3;
                        cnt            <= dwell_q - DWELL_W'(1);
                        {outer, inner} <= sens(P3, dir);
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                P3: begin
                    if (abort) begin
                        state          <= B2;
                        cnt            <= dwell_q - DWELL_W'(1);
                        {outer, inner} <= sens(B2, dir);
                    end else if (cnt == '0) begin
                        state          <= POST;
                        gap_cnt        <= GAP_LOAD;
                        done           <= 1'b1;
                        {outer, inner} <= 2'b00;
                        if (dir) exit_cnt  <= exit_cnt + 8'd1;
                        else     enter_cnt <= enter_cnt + 8'd1;
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                B2: begin
                    if (cnt == '0) begin
                        state          <= B1;
                        cnt            <= dwell_q - DWELL_W'(1);
                        {outer, inner} <= sens(B1, dir);
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                B1: begin
                    if (cnt == '0) begin
                        state          <= POST;
                        gap_cnt        <= GAP_LOAD;
                        {outer, inner} <= 2'b00;
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                POST: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    state          <= IDLE;
                    ready          <= 1'b1;
                    {outer, inner} <= 2'b00;
                end
            endcase
        end
    end

endmodule
